pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Fetch-side program-counter sequencer for the 3-stage MIPS core.
- Owns the PC register and issues instruction-memory requests over a req/ack handshake.
- Presents fetched instructions to decode with PC and PC+4. PC+4 is the base operand the branch-target adder consumes.
- Accepts a redirect (taken branch or jump target from the adder/decode), then flushes the fetch slot and restarts at the new PC.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address.
- RESET_PC, 32'h0000_0000, first fetch address after reset. Bits [1:0] are ignored.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  decode cannot accept; hold if_* outputs
redirect_valid  in  1  one-cycle pulse; change fetch flow
redirect_pc  in  ADDR_W  new fetch address (branch/jump target)
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address, word aligned
imem_ack  in  1  memory returns instr_in this cycle
instr_in  in  32  instruction data, valid with imem_ack
if_valid  out  1  if_instr/if_pc valid for decode
if_instr  out  32  fetched instruction
if_pc  out  ADDR_W  address of if_instr
if_pc_plus4  out  ADDR_W  if_pc + 4, feeds the branch-target adder
flush  out  1  one-cycle pulse on accepted redirect

Behaviour:
- Reset (async assert, sync release): state=BOOT, pc=RESET_PC&~3, and all outputs 0 (imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, flush). The skid buffer is empty and drop=0.
- States: BOOT, REQ, HOLD, DRAIN.
- All outputs are registered.
- BOOT:
  - Lasts one cycle after rst_n rises, then goes to REQ.
  - imem_req=1 and imem_addr=pc from the first REQ cycle.
- REQ:
  - imem_req=1 and imem_addr=pc; both are held stable until imem_ack.
  - An ack is accepted in any REQ cycle, including the first.
- On ack in REQ when the slot is free (!if_valid || !stall):
  - Capture if_instr=instr_in, if_pc=pc, if_pc_plus4=pc+4, if_valid=1.
  - pc <= pc+4. Stay in REQ, so the next request goes out the following cycle.
  - Sustained throughput is 1 instruction per cycle with zero-wait memory.
- On ack in REQ when the slot is occupied (if_valid && stall):
  - Store instruction and pc in the one-entry skid buffer; pc <= pc+4.
  - Go to HOLD.
- HOLD:
  - imem_req=0.
  - When stall=0: skid moves to the if_* outputs (if_valid stays 1), skid empties, go to REQ.
- No ack and decode consumes (if_valid && !stall): if_valid <= 0 next cycle.
- pc+4 wraps modulo 2^ADDR_W; 32'hFFFF_FFFC+4 = 0. if_pc_plus4 wraps the same way.
- Redirect (redirect_valid=1) has priority over stall and ack capture, in every state except BOOT:
  - pc <= redirect_pc & ~3.
  - if_valid <= 0 and the skid is cleared.
  - flush=1 for exactly the next cycle.
  - REQ with ack this cycle: the returned instruction is discarded; next state is REQ at the new pc.
  - REQ without ack: the outstanding request cannot be withdrawn. Go to DRAIN with imem_req=1 and the old imem_addr held.
  - HOLD: go to REQ.
- Redirect during BOOT: pc is updated and flush pulses; the first fetch uses the new pc.
- DRAIN:
  - Wait for imem_ack and discard the data (if_valid stays 0), then go to REQ at the redirect pc.
  - A second redirect in DRAIN overwrites pc and pulses flush again; stay in DRAIN.
- stall has no effect while if_valid=0. Instructions still fill the empty slot.
- Reset asserted mid-transaction abandons everything immediately; no ack is awaited after release.

Test Plan:
- Reset release, zero-wait memory (ack same cycle as req), stall=0: imem_addr = 0,4,8,C on consecutive cycles; if_valid high from cycle 2; if_pc_plus4 = if_pc+4 each cycle.
- Stall at if_pc=8 for 3 cycles, memory acks addr C: if_* hold 8 and the skid holds C; imem_req=0 while in HOLD. On release, if_pc=C, then a request for 10 is issued.
- Redirect to 32'h0000_0103 while the request for 14 is unacked, ack 2 cycles later: flush pulses once; imem_addr stays 14 until ack; that data is never shown (if_valid=0); next imem_addr=100.
- Redirect and ack in the same cycle (ack for 20, redirect 40): instruction at 20 is dropped; the next request is 40 and if_pc=40 on its ack.
- Redirect with stall=1 and if_valid=1: if_valid drops next cycle and flush=1; fetch resumes at the target regardless of stall.
- RESET_PC=32'hFFFF_FFF8: fetches FFFF_FFF8, FFFF_FFFC, 0000_0000. Also assert rst_n low while in DRAIN: all outputs go to 0 at once and the first request after release uses RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side PC register, imem req/ack handshake, one-entry skid and redirect flush
module pc_sequencer #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       instr_in,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic              flush
);
    typedef enum logic [1:0] {BOOT, REQ, HOLD, DRAIN} state_t;
    localparam logic [ADDR_W-1:0] boot_pc = {RESET_PC[ADDR_W-1:2], 2'b00};
    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, skid_pc, skid_pc_n, addr_n, if_pc_n, plus4_n;
    logic [31:0]       skid_instr, skid_instr_n, if_instr_n;
    logic              req_n, valid_n, flush_n;
    logic [ADDR_W-1:0] rpc;
    logic              pend;
    assign rpc  = {redirect_pc[ADDR_W-1:2], 2'b00};
    // a redirect that arrives without the ack leaves a request that cannot be withdrawn
    assign pend = (state != HOLD) && !imem_ack;
    // state, pc, skid and every output are registered together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= boot_pc;
            skid_pc     <= '0;
            skid_instr  <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            if_pc_plus4 <= '0;
            flush       <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            skid_pc     <= skid_pc_n;
            skid_instr  <= skid_instr_n;
            imem_req    <= req_n;
            imem_addr   <= addr_n;
            if_valid    <= valid_n;
            if_instr    <= if_instr_n;
            if_pc       <= if_pc_n;
            if_pc_plus4 <= plus4_n;
            flush       <= flush_n;
        end
    end
    // next state and next registered outputs; redirect outranks stall and ack outside BOOT
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        skid_pc_n    = skid_pc;
        skid_instr_n = skid_instr;
        req_n        = imem_req;
        addr_n       = imem_addr;
        valid_n      = if_valid;
        if_instr_n   = if_instr;
        if_pc_n      = if_pc;
        plus4_n      = if_pc_plus4;
        flush_n      = 1'b0;
        if (state != BOOT && redirect_valid) begin
            pc_n         = rpc;
            valid_n      = 1'b0;
            skid_pc_n    = '0;
            skid_instr_n = '0;
            flush_n      = 1'b1;
            req_n        = 1'b1;
            addr_n       = pend ? imem_addr : rpc;
            state_n      = pend ? DRAIN : REQ;
        end else begin
            case (state)
                BOOT: begin
                    pc_n    = redirect_valid ? rpc : pc;
                    flush_n = redirect_valid;
                    state_n = REQ;
                    req_n   = 1'b1;
                    addr_n  = pc_n;
                end
                REQ: begin
                    if (imem_ack && (!if_valid || !stall)) begin
                        if_instr_n = instr_in;
                        if_pc_n    = pc;
                        plus4_n    = pc + ADDR_W'(4);
                        valid_n    = 1'b1;
                        pc_n       = pc + ADDR_W'(4);
                        addr_n     = pc_n;
                    end else if (imem_ack) begin
                        skid_instr_n = instr_in;
                        skid_pc_n    = pc;
                        pc_n         = pc + ADDR_W'(4);
                        req_n        = 1'b0;
                        state_n      = HOLD;
                    end else if (if_valid && !stall) begin
                        valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_instr_n = skid_instr;
                        if_pc_n    = skid_pc;
                        plus4_n    = skid_pc + ADDR_W'(4);
                        valid_n    = 1'b1;
                        req_n      = 1'b1;
                        addr_n     = pc;
                        state_n    = REQ;
                    end
                end
                default: begin
                    if (imem_ack) begin
                        addr_n  = pc;
                        state_n = REQ;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors for the fetch sequencer, including RESET_PC wrap on a second instance
module tb_pc_sequencer;
    localparam logic [31:0] PAT = 32'hA5A5_0000;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1, rst1_n = 1'b1;
    logic        stall = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        auto_ack = 1'b1, man_ack = 1'b0;
    logic        imem_req, imem_ack, if_valid, flush;
    logic [31:0] imem_addr, instr_in, if_instr, if_pc, if_pc_plus4;
    logic        imem_req1, if_valid1, flush1;
    logic [31:0] imem_addr1, if_instr1, if_pc1, if_pc_plus41;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign imem_ack = auto_ack ? imem_req : man_ack;
    assign instr_in = imem_addr ^ PAT;

    pc_sequencer u0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .instr_in(instr_in), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .flush(flush)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFF8)) u1 (
        .clk(clk), .rst_n(rst1_n), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_req(imem_req1), .imem_addr(imem_addr1),
        .imem_ack(imem_req1), .instr_in(imem_addr1 ^ PAT), .if_valid(if_valid1),
        .if_instr(if_instr1), .if_pc(if_pc1), .if_pc_plus4(if_pc_plus41), .flush(flush1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst_n = 1'b0; rst1_n = 1'b0;
        #8;
        check("rst_req", {31'b0, imem_req}, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", {31'b0, if_valid}, 0);
        check("rst_flush", {31'b0, flush}, 0);
        check("rst1_addr", imem_addr1, 0);
        tick(); rst_n = 1'b1;
        tick();
        check("boot_req", {31'b0, imem_req}, 1);
        check("addr0", imem_addr, 32'h0);
        check("boot_valid", {31'b0, if_valid}, 0);
        tick();
        check("addr4", imem_addr, 32'h4);
        check("v_c2", {31'b0, if_valid}, 1);
        check("pc_c2", if_pc, 32'h0);
        check("p4_c2", if_pc_plus4, 32'h4);
        tick();
        check("addr8", imem_addr, 32'h8);
        check("pc_c3", if_pc, 32'h4);
        tick();
        check("addrC", imem_addr, 32'hC);
        check("pc_c4", if_pc, 32'h8);
        check("p4_c4", if_pc_plus4, 32'hC);
        check("instr8", if_instr, 32'h8 ^ PAT);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_req", {31'b0, imem_req}, 0);
            check("hold_pc", if_pc, 32'h8);
            check("hold_v", {31'b0, if_valid}, 1);
        end
        stall = 1'b0;
        tick();
        check("skid_pc", if_pc, 32'hC);
        check("skid_instr", if_instr, 32'hC ^ PAT);
        check("skid_p4", if_pc_plus4, 32'h10);
        check("req10", imem_addr, 32'h10);
        check("req10_v", {31'b0, imem_req}, 1);
        tick();
        check("addr14", imem_addr, 32'h14);
        auto_ack = 1'b0; man_ack = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        check("dr_flush", {31'b0, flush}, 1);
        check("dr_valid", {31'b0, if_valid}, 0);
        check("dr_addr", imem_addr, 32'h14);
        check("dr_req", {31'b0, imem_req}, 1);
        tick();
        check("dr_flush2", {31'b0, flush}, 0);
        check("dr_addr2", imem_addr, 32'h14);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0; auto_ack = 1'b1;
        check("dr_done_v", {31'b0, if_valid}, 0);
        check("addr100", imem_addr, 32'h100);
        tick();
        check("pc100", if_pc, 32'h100);
        check("instr100", if_instr, 32'h100 ^ PAT);
        check("addr104", imem_addr, 32'h104);
        tick();
        check("addr108", imem_addr, 32'h108);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("ra_addr", imem_addr, 32'h40);
        check("ra_valid", {31'b0, if_valid}, 0);
        check("ra_flush", {31'b0, flush}, 1);
        tick();
        check("ra_pc", if_pc, 32'h40);
        check("ra_instr", if_instr, 32'h40 ^ PAT);
        check("ra_flush2", {31'b0, flush}, 0);
        check("addr44", imem_addr, 32'h44);
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check("rs_valid", {31'b0, if_valid}, 0);
        check("rs_flush", {31'b0, flush}, 1);
        check("rs_addr", imem_addr, 32'h200);
        tick();
        check("rs_fill_v", {31'b0, if_valid}, 1);
        check("rs_fill_pc", if_pc, 32'h200);
        check("addr204", imem_addr, 32'h204);
        tick();
        check("rs_hold_req", {31'b0, imem_req}, 0);
        check("rs_hold_pc", if_pc, 32'h200);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        check("rh_addr", imem_addr, 32'h300);
        check("rh_req", {31'b0, imem_req}, 1);
        check("rh_valid", {31'b0, if_valid}, 0);
        auto_ack = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h500;
        tick();
        redirect_valid = 1'b0;
        check("d2_addr", imem_addr, 32'h300);
        check("d2_flush", {31'b0, flush}, 1);
        rst_n = 1'b0;
        #1;
        check("ar_req", {31'b0, imem_req}, 0);
        check("ar_addr", imem_addr, 0);
        check("ar_flush", {31'b0, flush}, 0);
        check("ar_valid", {31'b0, if_valid}, 0);
        check("ar_pc", if_pc, 0);
        tick();
        rst_n = 1'b1; auto_ack = 1'b1;
        tick();
        check("rr_req", {31'b0, imem_req}, 1);
        check("rr_addr", imem_addr, 32'h0);
        tick();
        check("rr_pc", if_pc, 32'h0);
        check("rr_v", {31'b0, if_valid}, 1);
        rst1_n = 1'b1;
        tick();
        check("w_addr0", imem_addr1, 32'hFFFF_FFF8);
        tick();
        check("w_addr1", imem_addr1, 32'hFFFF_FFFC);
        check("w_pc0", if_pc1, 32'hFFFF_FFF8);
        tick();
        check("w_addr2", imem_addr1, 32'h0);
        check("w_pc1", if_pc1, 32'hFFFF_FFFC);
        check("w_p4", if_pc_plus41, 32'h0);
        tick();
        check("w_pc2", if_pc1, 32'h0);
        check("w_p4b", if_pc_plus41, 32'h4);
        check("w_instr", if_instr1, 32'h0 ^ PAT);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
